// File: rtl/startup_seq_pkg.sv
// Shared types and sizing helpers for the power-up sequencer.
// Holds the FSM state encoding and the width functions used to size the
// stage index, retry counter and shared cycle counter.
package startup_seq_pkg;

  // Sequencer states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_OFF    = 3'd3,
    ST_RUN    = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  // Bits needed to index 'count' items, never less than one bit so the
  // ports stay legal when only one stage or zero retries are configured.
  function automatic int idx_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  // Bits needed by the shared cycle counter: it must hold the longer of
  // the READY timeout and the settle / off window without wrapping.
  function automatic int cnt_width(input int timeout_cycles, input int settle_cycles);
    int longest;
    longest = (timeout_cycles > settle_cycles) ? timeout_cycles : settle_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage : startup_seq_pkg

// File: rtl/ready_sync.sv
// Two-flop synchronizer bank for the per-subsystem READY handshakes.
// Each bit is synchronized independently; both stages clear on the
// synchronous clear so no stale READY survives a system reset.
module ready_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back capture stages per bit, cleared together
  always_ff @(posedge clk) begin
    if (clr) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule : ready_sync

// File: rtl/startup_sequencer.sv
// Power-up sequencer: enables N_STAGES subsystems one at a time, waits for
// each READY handshake, retries on timeout and latches a sticky fault when
// the retries of a stage are exhausted. SYS_UP rises once every stage has
// been ready and settled.
//
// Build option: define STARTUP_SEQ_RUNTIME_MON_EN to keep watching READY
// after SYS_UP. A stage that stays not-ready for two consecutive cycles then
// drops SYS_UP and every ENABLE, and after an off-time of SETTLE_CYCLES the
// whole sequence restarts from stage 0. Without it RUN is terminal until
// RESET.
module startup_sequencer
  import startup_seq_pkg::*;
#(
  parameter int N_STAGES       = 4,
  parameter int SETTLE_CYCLES  = 48000,
  parameter int TIMEOUT_CYCLES = 480000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                                  CLK_48MHZ,
  input  logic                                  RESET,
  input  logic [N_STAGES-1:0]                   READY,
  output logic [N_STAGES-1:0]                   ENABLE,
  output logic                                  SYS_UP,
  output logic                                  FAULT,
  output logic [idx_width(N_STAGES)-1:0]        FAULT_STAGE,
  output logic [idx_width(MAX_RETRIES+1)-1:0]   RETRY_CNT
);

  localparam int KW = idx_width(N_STAGES);
  localparam int RW = idx_width(MAX_RETRIES + 1);
  localparam int CW = cnt_width(TIMEOUT_CYCLES, SETTLE_CYCLES);

  localparam logic [CW-1:0]       TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]       SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [KW-1:0]       LAST_STAGE   = KW'(N_STAGES - 1);
  localparam logic [RW-1:0]       RETRY_MAX    = RW'(MAX_RETRIES);
  localparam logic [N_STAGES-1:0] EN_ONE       = N_STAGES'(1);

  // Synchronized READY, three edges from pin to FSM decision
  logic [N_STAGES-1:0] ready_s;

  ready_sync #(
    .WIDTH (N_STAGES)
  ) u_ready_sync (
    .clk (CLK_48MHZ),
    .clr (RESET),
    .d   (READY),
    .q   (ready_s)
  );

  state_e              state_q,       state_d;
  logic [KW-1:0]       k_q,           k_d;
  logic [CW-1:0]       cnt_q,         cnt_d;
  logic [N_STAGES-1:0] enable_q,      enable_d;
  logic                sys_up_q,      sys_up_d;
  logic                fault_q,       fault_d;
  logic [KW-1:0]       fault_stage_q, fault_stage_d;
  logic [RW-1:0]       retry_q,       retry_d;

`ifdef STARTUP_SEQ_RUNTIME_MON_EN
  // restart_q marks an IDLE entered from RUN, which must hold off for the
  // settle window; low_q remembers which stages were not ready last cycle.
  logic                restart_q,     restart_d;
  logic [N_STAGES-1:0] low_q,         low_d;
`endif

  // Only the stage currently being sequenced is looked at; earlier stages
  // stay enabled and their READY is ignored until RUN.
  logic stage_ready;
  assign stage_ready = ready_s[k_q];

  // Next-state and next-output decode for the sequencer FSM and counter
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    k_d           = k_q;
    cnt_d         = cnt_q + 1'b1;
    enable_d      = enable_q;
    sys_up_d      = sys_up_q;
    fault_d       = fault_q;
    fault_stage_d = fault_stage_q;
    retry_d       = retry_q;
`ifdef STARTUP_SEQ_RUNTIME_MON_EN
    restart_d     = restart_q;
    low_d         = '0;
`endif

    unique case (state_q)
      ST_IDLE: begin
`ifdef STARTUP_SEQ_RUNTIME_MON_EN
        if (!restart_q || (cnt_q == SETTLE_LAST)) begin
`else
        begin
`endif
          state_d  = ST_WAIT;
          k_d      = '0;
          retry_d  = '0;
          enable_d = EN_ONE;
`ifdef STARTUP_SEQ_RUNTIME_MON_EN
          restart_d = 1'b0;
`endif
        end
      end

      ST_WAIT: begin
        // A READY arriving on the timeout cycle still counts as success
        if (stage_ready) begin
          state_d = ST_SETTLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_q < RETRY_MAX) begin
            state_d       = ST_OFF;
            enable_d[k_q] = 1'b0;
          end else begin
            state_d       = ST_FAULT;
            enable_d      = '0;
            fault_d       = 1'b1;
            fault_stage_d = k_q;
          end
        end
      end

      ST_SETTLE: begin
        // Losing READY restarts the wait without spending a retry
        if (!stage_ready) begin
          state_d = ST_WAIT;
        end else if (cnt_q == SETTLE_LAST) begin
          if (k_q == LAST_STAGE) begin
            state_d  = ST_RUN;
            sys_up_d = 1'b1;
          end else begin
            state_d  = ST_WAIT;
            k_d      = k_q + 1'b1;
            retry_d  = '0;
            enable_d = enable_q | (EN_ONE << k_d);
          end
        end
      end

      ST_OFF: begin
        // The retry is charged when the stage is powered again
        if (cnt_q == SETTLE_LAST) begin
          state_d       = ST_WAIT;
          retry_d       = retry_q + 1'b1;
          enable_d[k_q] = 1'b1;
        end
      end

      ST_RUN: begin
`ifdef STARTUP_SEQ_RUNTIME_MON_EN
        // A stage not ready on two consecutive cycles tears the system down
        low_d = ~ready_s;
        if (|(low_q & ~ready_s)) begin
          state_d   = ST_IDLE;
          k_d       = '0;
          retry_d   = '0;
          enable_d  = '0;
          sys_up_d  = 1'b0;
          restart_d = 1'b1;
          low_d     = '0;
        end
`endif
      end

      ST_FAULT: begin
        // Sticky: only RESET leaves this state
      end

      default: begin
        state_d  = ST_IDLE;
        enable_d = '0;
        sys_up_d = 1'b0;
      end
    endcase

    // The counter restarts on every state entry and idles in the end states
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == ST_RUN) || (state_q == ST_FAULT)) begin
      cnt_d = cnt_q;
    end
  end

  // State, counter and registered outputs, synchronous reset
  always_ff @(posedge CLK_48MHZ) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (RESET) begin
      state_q       <= ST_IDLE;
      k_q           <= '0;
      cnt_q         <= '0;
      enable_q      <= '0;
      sys_up_q      <= 1'b0;
      fault_q       <= 1'b0;
      fault_stage_q <= '0;
      retry_q       <= '0;
`ifdef STARTUP_SEQ_RUNTIME_MON_EN
      restart_q     <= 1'b0;
      low_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      cnt_q         <= cnt_d;
      enable_q      <= enable_d;
      sys_up_q      <= sys_up_d;
      fault_q       <= fault_d;
      fault_stage_q <= fault_stage_d;
      retry_q       <= retry_d;
`ifdef STARTUP_SEQ_RUNTIME_MON_EN
      restart_q     <= restart_d;
      low_q         <= low_d;
`endif
    end
  end

  assign ENABLE      = enable_q;
  assign SYS_UP      = sys_up_q;
  assign FAULT       = fault_q;
  assign FAULT_STAGE = fault_stage_q;
  assign RETRY_CNT   = retry_q;

endmodule : startup_sequencer

// File: tb/tb_startup_sequencer.sv
// Directed bench for startup_sequencer with N_STAGES=3, SETTLE_CYCLES=4,
// TIMEOUT_CYCLES=10, MAX_RETRIES=2. Expected output values are queued with
// the cycle they belong to and compared when that cycle is reached.
// Cycle n is the state after the n-th rising edge that sampled RESET low.
module tb_startup_sequencer;

  logic       clk_48mhz = 1'b0;
  logic       reset     = 1'b1;
  logic [2:0] ready     = 3'b000;
  logic [2:0] enable;
  logic       sys_up;
  logic       fault;
  logic [1:0] fault_stage;
  logic [1:0] retry_cnt;

  always #5 clk_48mhz = ~clk_48mhz;

  startup_sequencer #(
    .N_STAGES       (3),
    .SETTLE_CYCLES  (4),
    .TIMEOUT_CYCLES (10),
    .MAX_RETRIES    (2)
  ) dut (
    .CLK_48MHZ   (clk_48mhz),
    .RESET       (reset),
    .READY       (ready),
    .ENABLE      (enable),
    .SYS_UP      (sys_up),
    .FAULT       (fault),
    .FAULT_STAGE (fault_stage),
    .RETRY_CNT   (retry_cnt)
  );

  typedef enum int {SIG_EN, SIG_UP, SIG_FLT, SIG_FSTG, SIG_RTY} sig_e;

  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   vectors;
  int   miscompares;

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      SIG_EN:   return {29'd0, enable};
      SIG_UP:   return {31'd0, sys_up};
      SIG_FLT:  return {31'd0, fault};
      SIG_FSTG: return {30'd0, fault_stage};
      SIG_RTY:  return {30'd0, retry_cnt};
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push_exp(input int c, input string tag, input sig_e s, input logic [31:0] v);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check(input exp_t e);
    logic [31:0] obs;
    obs = observe(e.sig);
    vectors++;
    assert ((e.cyc == cyc) && (obs === e.val)) else begin
      miscompares++;
      $error("FAIL %s @cycle %0d (now %0d): observed 0x%0h expected 0x%0h",
             e.tag, e.cyc, cyc, obs, e.val);
    end
  endtask

  task automatic drain();
    while ((sb.size() > 0) && (sb[0].cyc <= cyc)) check(sb.pop_front());
  endtask

  task automatic tick();
    @(posedge clk_48mhz);
    #1;
    cyc++;
    drain();
  endtask

  task automatic run_until(input int c);
    while (cyc < c) tick();
  endtask

  // Two reset edges, reset values checked, RESET released before cycle 1
  task automatic apply_reset(input logic [2:0] rdy);
    ready = rdy;
    reset = 1'b1;
    cyc   = -2;
    push_exp(0, "rst_enable",      SIG_EN,   32'd0);
    push_exp(0, "rst_sys_up",      SIG_UP,   32'd0);
    push_exp(0, "rst_fault",       SIG_FLT,  32'd0);
    push_exp(0, "rst_fault_stage", SIG_FSTG, 32'd0);
    push_exp(0, "rst_retry_cnt",   SIG_RTY,  32'd0);
    run_until(0);
    reset = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = -2;

    // All stages ready from the start: SYS_UP at cycle 17
    apply_reset(3'b111);
    push_exp(1,  "t1_en_s0",      SIG_EN,  32'b001);
    push_exp(6,  "t1_en_s0_hold", SIG_EN,  32'b001);
    push_exp(7,  "t1_en_s1",      SIG_EN,  32'b011);
    push_exp(11, "t1_en_s1_hold", SIG_EN,  32'b011);
    push_exp(12, "t1_en_s2",      SIG_EN,  32'b111);
    push_exp(16, "t1_up_early",   SIG_UP,  32'd0);
    push_exp(17, "t1_up",         SIG_UP,  32'd1);
    push_exp(17, "t1_en_all",     SIG_EN,  32'b111);
    push_exp(17, "t1_fault",      SIG_FLT, 32'd0);
    push_exp(30, "t1_up_stays",   SIG_UP,  32'd1);
    push_exp(30, "t1_en_stays",   SIG_EN,  32'b111);
    run_until(30);

    // Stage 1 never ready: two off windows, then sticky fault on stage 1
    apply_reset(3'b101);
    push_exp(7,  "t2_en_s1",       SIG_EN,   32'b011);
    push_exp(16, "t2_en_wait",     SIG_EN,   32'b011);
    push_exp(17, "t2_off1",        SIG_EN,   32'b001);
    push_exp(20, "t2_off1_hold",   SIG_EN,   32'b001);
    push_exp(21, "t2_retry1_en",   SIG_EN,   32'b011);
    push_exp(21, "t2_retry1_cnt",  SIG_RTY,  32'd1);
    push_exp(31, "t2_off2",        SIG_EN,   32'b001);
    push_exp(35, "t2_retry2_en",   SIG_EN,   32'b011);
    push_exp(35, "t2_retry2_cnt",  SIG_RTY,  32'd2);
    push_exp(44, "t2_pre_fault_en",SIG_EN,   32'b011);
    push_exp(44, "t2_pre_fault",   SIG_FLT,  32'd0);
    push_exp(45, "t2_fault",       SIG_FLT,  32'd1);
    push_exp(45, "t2_fault_en",    SIG_EN,   32'b000);
    push_exp(45, "t2_fault_stage", SIG_FSTG, 32'd1);
    push_exp(45, "t2_fault_retry", SIG_RTY,  32'd2);
    for (int c = 55; c <= 145; c += 10) begin
      push_exp(c, "t2_sticky_fault", SIG_FLT,  32'd1);
      push_exp(c, "t2_sticky_en",    SIG_EN,   32'b000);
      push_exp(c, "t2_sticky_stage", SIG_FSTG, 32'd1);
      push_exp(c, "t2_sticky_retry", SIG_RTY,  32'd2);
      push_exp(c, "t2_sticky_up",    SIG_UP,   32'd0);
    end
    run_until(50);
    ready = 3'b111;
    run_until(145);

    // Stage 2 ready 3 cycles into its second attempt
    apply_reset(3'b011);
    push_exp(12, "t3_en_s2",       SIG_EN,  32'b111);
    push_exp(21, "t3_en_wait",     SIG_EN,  32'b111);
    push_exp(22, "t3_off",         SIG_EN,  32'b011);
    push_exp(25, "t3_off_hold",    SIG_EN,  32'b011);
    push_exp(26, "t3_retry_en",    SIG_EN,  32'b111);
    push_exp(26, "t3_retry_cnt",   SIG_RTY, 32'd1);
    push_exp(34, "t3_up_early",    SIG_UP,  32'd0);
    push_exp(35, "t3_up",          SIG_UP,  32'd1);
    push_exp(35, "t3_retry_final", SIG_RTY, 32'd1);
    push_exp(35, "t3_fault",       SIG_FLT, 32'd0);
    push_exp(40, "t3_up_stays",    SIG_UP,  32'd1);
    run_until(28);
    ready = 3'b111;
    run_until(40);

    // Stage 0 READY glitch mid-settle: back to WAIT, SYS_UP 4 cycles late
    apply_reset(3'b111);
    push_exp(7,  "t4_en_not_adv", SIG_EN,  32'b001);
    push_exp(11, "t4_en_s1",      SIG_EN,  32'b011);
    push_exp(16, "t4_en_s2",      SIG_EN,  32'b111);
    push_exp(20, "t4_up_early",   SIG_UP,  32'd0);
    push_exp(21, "t4_up",         SIG_UP,  32'd1);
    push_exp(21, "t4_no_retry",   SIG_RTY, 32'd0);
    run_until(3);
    ready = 3'b110;
    run_until(4);
    ready = 3'b111;
    run_until(21);

    // RESET pulse while stage 1 waits, then full rerun
    apply_reset(3'b101);
    push_exp(7,  "t5_en_s1",   SIG_EN, 32'b011);
    push_exp(11, "t5_en_drop", SIG_EN, 32'b000);
    push_exp(11, "t5_up_drop", SIG_UP, 32'd0);
    run_until(10);
    reset = 1'b1;
    run_until(11);
    reset = 1'b0;
    ready = 3'b111;
    cyc   = 0;
    push_exp(1,  "t5_rerun_en_s0", SIG_EN, 32'b001);
    push_exp(16, "t5_up_early",    SIG_UP, 32'd0);
    push_exp(17, "t5_up",          SIG_UP, 32'd1);
    push_exp(17, "t5_en_all",      SIG_EN, 32'b111);

    // Runtime READY loss in RUN: 1-cycle glitch, then 2-cycle drop
    push_exp(26, "t6_glitch_up", SIG_UP, 32'd1);
    push_exp(26, "t6_glitch_en", SIG_EN, 32'b111);
    push_exp(33, "t6_drop_up_1", SIG_UP, 32'd1);
`ifdef STARTUP_SEQ_RUNTIME_MON_EN
    push_exp(34, "t6_mon_up",      SIG_UP,  32'd0);
    push_exp(34, "t6_mon_en",      SIG_EN,  32'b000);
    push_exp(37, "t6_holdoff_en",  SIG_EN,  32'b000);
    push_exp(38, "t6_reseq_en_s0", SIG_EN,  32'b001);
    push_exp(43, "t6_reseq_en_s1", SIG_EN,  32'b011);
    push_exp(52, "t6_reseq_early", SIG_UP,  32'd0);
    push_exp(53, "t6_reseq_up",    SIG_UP,  32'd1);
    push_exp(53, "t6_reseq_en",    SIG_EN,  32'b111);
    push_exp(53, "t6_reseq_retry", SIG_RTY, 32'd0);
`else
    push_exp(34, "t6_ignored_up", SIG_UP, 32'd1);
    push_exp(34, "t6_ignored_en", SIG_EN, 32'b111);
    push_exp(53, "t6_still_up",   SIG_UP, 32'd1);
    push_exp(53, "t6_still_en",   SIG_EN, 32'b111);
`endif
    run_until(20);
    ready = 3'b101;
    run_until(21);
    ready = 3'b111;
    run_until(30);
    ready = 3'b101;
    run_until(32);
    ready = 3'b111;
    run_until(53);

    // Every queued expectation must have been reached
    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %0d pending expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_startup_sequencer

// File: doc/startup_sequencer.md
# startup_sequencer

Power-up sequencer directly downstream of the board reset generator: consumes the conditioned 48 MHz clock and the synchronous active-high system reset, then enables the avionics subsystems one by one in fixed order. Each stage waits for its READY handshake, retries on timeout, and declares a sticky fault if retries run out. Asserts SYS_UP once every stage is up and settled; application logic holds off until then.

## Interface
- N_STAGES, 4: number of sequenced subsystems; stage 0 is enabled first.
- SETTLE_CYCLES, 48000: cycles a stage must stay ready before the next stage is enabled; also the off-time before a retry (1 ms at 48 MHz).
- TIMEOUT_CYCLES, 480000: cycles allowed for READY after ENABLE (10 ms).
- MAX_RETRIES, 3: retries per stage after the first attempt.

Ports:
- CLK_48MHZ  in  1  system clock, the conditioned clock from the reset generator.
- RESET  in  1  synchronous, active-high reset from the reset generator.
- READY  in  N_STAGES  per-subsystem ready, asynchronous to CLK_48MHZ.
- ENABLE  out  N_STAGES  per-subsystem enable, registered.
- SYS_UP  out  1  all stages up and settled.
- FAULT  out  1  sticky sequencing fault.
- FAULT_STAGE  out  clog2(N_STAGES)  index of the failed stage; valid while FAULT is high.
- RETRY_CNT  out  clog2(MAX_RETRIES+1)  retries used on the current or failed stage.

## Operation
- READY passes through a 2-flop synchronizer per bit; the output is ready_s. The synchronizer flops clear on RESET.
- One shared cycle counter, width clog2(max(TIMEOUT_CYCLES, SETTLE_CYCLES)+1). It clears on every state entry.
- Stage index k clears to 0 on reset.
- States and transitions:
  - IDLE: on reset. Next cycle goes to WAIT and sets ENABLE[0].
  - WAIT: ENABLE[k] is high.
    - ready_s[k]=1 goes to SETTLE.
    - Counter reaching TIMEOUT_CYCLES-1 with ready_s[k]=0 goes to OFF if RETRY_CNT<MAX_RETRIES, otherwise to FAULT.
  - SETTLE:
    - ready_s[k]=0 returns to WAIT with the counter cleared; RETRY_CNT is unchanged.
    - Counter reaching SETTLE_CYCLES-1 goes to RUN if k=N_STAGES-1. Otherwise k increments, RETRY_CNT clears, ENABLE[k+1] sets and the state goes to WAIT.
  - OFF: ENABLE[k]=0 for SETTLE_CYCLES cycles, RETRY_CNT increments, then back to WAIT with ENABLE[k]=1.
  - RUN: SYS_UP=1 and all ENABLE stay high.
  - FAULT: ENABLE all 0, FAULT=1, FAULT_STAGE=k, RETRY_CNT frozen. Only RESET exits FAULT.
- Enabled earlier stages stay enabled; their READY is ignored while sequencing.
- Simultaneous ready_s[k]=1 and timeout in the same cycle: ready wins.
- RESET mid-sequence: all ENABLE drop on the next edge and sequencing restarts from stage 0.

## Timing
- Reset values: ENABLE=0, SYS_UP=0, FAULT=0, FAULT_STAGE=0, RETRY_CNT=0, state IDLE.
- Cycle 1 is the first rising edge with RESET sampled low; IDLE to WAIT happens there.
- READY-to-decision latency is 3 edges: 2 in the synchronizer plus 1 registered transition.
- WAIT lasts at most TIMEOUT_CYCLES cycles. SETTLE lasts exactly SETTLE_CYCLES cycles. OFF lasts exactly SETTLE_CYCLES cycles.
- All outputs are registered, with no combinational path from input to output.

## Configuration
- STARTUP_SEQ_RUNTIME_MON_EN defined:
  - In RUN, ready_s[i]=0 on any stage for 2 consecutive cycles drops SYS_UP and all ENABLE.
  - The block then waits SETTLE_CYCLES and resequences from stage 0. RETRY_CNT clears.
- Not defined: READY is ignored in RUN and RUN is terminal until RESET.

## Structure
- Package startup_seq_pkg holds:
  - the state encoding: IDLE, WAIT, SETTLE, OFF, RUN, FAULT (3 bits);
  - the counter-width and index-width helper functions.
- Sub-module ready_sync: parameterised-width 2-flop synchronizer with synchronous clear.
- All other logic is one FSM plus the counter in startup_sequencer.

## Test plan
Bench parameters: N_STAGES=3, SETTLE_CYCLES=4, TIMEOUT_CYCLES=10, MAX_RETRIES=2.
- READY=111 throughout → ENABLE goes 001, 011, 111. SYS_UP rises at cycle 17 and stays high. FAULT=0.
- READY[1] held 0 → ENABLE[1] goes low twice for 4 cycles each. Then FAULT=1, FAULT_STAGE=1, RETRY_CNT=2, ENABLE=000. Check the values persist for 100 cycles.
- READY[2] rises 3 cycles into its second attempt → RETRY_CNT=1, SYS_UP=1, FAULT=0.
- READY[0] drops for 1 cycle mid-SETTLE → returns to WAIT. SYS_UP is delayed by the re-settle; no retry is counted.
- RESET pulsed while stage 1 is in WAIT → ENABLE=000 on the next edge. Full sequence reruns and SYS_UP rises 17 cycles after release.
- With STARTUP_SEQ_RUNTIME_MON_EN, READY[1] low for 2 cycles in RUN → SYS_UP=0 and ENABLE=000, then resequence. A 1-cycle glitch is ignored. Without the macro, both are ignored.
